snitch_icache_flush_ctrl: RTL and testbench
===========================================

# snitch_icache_flush_ctrl

Flush/invalidate sequencer for the L1 instruction cache tag array, placed beside the L1 lookup stage and sharing the tag-SRAM write port with the refill path. On reset, and on each software flush request, it stops new lookups and waits for in-flight lookups and refills to drain. It then pulses a flush to every L0 and walks all sets, clearing every way's tag. Finally it releases the cache.

## Interface

- LINE_COUNT, default 128: number of L1 sets (lines per way); ≥1.
- WAY_COUNT, default 4: number of L1 ways; ≥1.
- NR_FETCH_PORTS, default 2: number of L0 caches (fetch ports).
- SET_ALIGN, derived: max(1, $clog2(LINE_COUNT)).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_valid_i  in  1  flush request; held high until flush_ready_o.
- flush_ready_o  out  1  one-cycle completion acknowledge.
- busy_o  out  1  high in any state other than IDLE.
- lookup_stall_o  out  1  blocks new L1 lookups; equals busy_o.
- lookup_idle_i  in  1  no lookup in flight in the L1 pipeline.
- refill_pending_i  in  1  at least one refill outstanding.
- l0_flush_o  out  NR_FETCH_PORTS  one-cycle invalidate pulse to each L0, all bits together.
- tag_req_valid_o  out  1  tag write request.
- tag_req_ready_i  in  1  tag port accepts the request.
- tag_addr_o  out  SET_ALIGN  set index being cleared.
- tag_way_mask_o  out  WAY_COUNT  constant all-ones while tag_req_valid_o is high, else 0.
- tag_write_o  out  1  equals tag_req_valid_o; the write data is zero (valid bit cleared), driven by the tag port.

## Operation

- States: IDLE, DRAIN, INVAL, DONE. Registers: state, set counter set_q (SET_ALIGN bits), sw_q (software-initiated flag).
- Reset: state = DRAIN, set_q = 0, sw_q = 0. An automatic init flush runs because tag SRAM contents are undefined at power-up.
- IDLE to DRAIN: when flush_valid_i = 1. Set sw_q = 1.
- DRAIN to INVAL: when lookup_idle_i = 1 and refill_pending_i = 0 in the same cycle.
  - On that transition edge, l0_flush_o is all-ones for exactly one cycle (the first INVAL cycle).
  - If the conditions never occur, the block stays in DRAIN. There is no timeout.
- INVAL:
  - tag_req_valid_o = 1 and tag_addr_o = set_q.
  - Once valid rises, it and the address stay stable until the handshake completes.
  - On tag_req_ready_i = 1: if set_q = LINE_COUNT-1, go to DONE and set set_q = 0; otherwise increment set_q.
- DONE:
  - flush_ready_o = sw_q. Clear sw_q. Next state is IDLE.
  - An init flush completes silently, with no flush_ready_o.
- A flush_valid_i that is high while busy (for example, during the init flush) is not merged with the current flush. It is served as a new flush once IDLE is re-entered.
- A flush_valid_i that stays high after flush_ready_o starts another flush. Requesters must drop valid on the ready cycle.
- LINE_COUNT = 1: INVAL issues exactly one request, at address 0.
- The refill path must not write tags while busy_o = 1. The drain guarantees that no refill is outstanding at entry, and lookup_stall_o prevents new misses.

## Timing

- Reset values:
  - busy_o = 1, lookup_stall_o = 1 (state DRAIN).
  - flush_ready_o = 0, l0_flush_o = 0.
  - tag_req_valid_o = 0, tag_write_o = 0, tag_addr_o = 0, tag_way_mask_o = 0.
- All outputs are registered-state decodes, with no combinational path from any input to any output. The only exception is tag_addr_o, which follows set_q.
- Software flush with idle pipeline and tag_req_ready_i tied high (request seen in IDLE at cycle 0):
  - cycle 1: DRAIN.
  - cycles 2 .. LINE_COUNT+1: INVAL, set k written at cycle 2+k; l0_flush_o pulses at cycle 2.
  - cycle LINE_COUNT+2: DONE, flush_ready_o = 1.
  - cycle LINE_COUNT+3: IDLE, busy_o = 0.
- Init flush with the same conditions: DRAIN at the first cycle after reset release, then the same sequence, reaching IDLE LINE_COUNT+2 cycles after reset release.
- Back-pressure adds one cycle per cycle in which tag_req_ready_i = 0.
- An asynchronous reset at any point (including mid-INVAL) immediately returns the block to reset state. The walk restarts from set 0 as an init flush, and any pending software acknowledge is lost.

## Test plan

- Init flush (LINE_COUNT=8, WAY_COUNT=4, ready=1, idle=1, pending=0): release reset. Expected: addresses 0..7 on 8 consecutive cycles with way mask 4'b1111; one l0_flush_o pulse; no flush_ready_o; busy_o falls 10 cycles after release.
- Software flush, same configuration: flush_valid_i at cycle 0 in IDLE. Expected: flush_ready_o is high exactly at cycle 10 and busy_o = 0 at cycle 11.
- Drain gating: raise refill_pending_i for 5 cycles after the request. Expected: no tag_req_valid_o and no l0_flush_o until 1 cycle after pending falls, and lookup_stall_o stays high throughout.
- Back-pressure: tag_req_ready_i alternates 0/1. Expected: each address is held stable until accepted, all 8 sets are written once in order, and DONE arrives after 16 INVAL cycles.
- Request during init flush: flush_valid_i high from reset release. Expected: two full walks occur; flush_ready_o asserts once, at the end of the second walk.
- Reset mid-walk: assert rst_ni low while set 5 is being written. Expected: outputs take reset values immediately; after release, the walk restarts at set 0 and produces no flush_ready_o.

Source files
------------

// File: rtl/snitch_icache_flush_ctrl.sv
// Flush/invalidate sequencer for the L1 instruction cache tag array.
// On reset and on each software flush request it stalls lookups, drains
// in-flight lookups and refills, pulses an invalidate to every L0, then
// walks every set clearing all ways' tags before releasing the cache.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_valid_i/ready_o software flush request / one-cycle acknowledge
//   busy_o, lookup_stall_o high whenever the sequencer is not idle
//   lookup_idle_i        no lookup in flight in the L1 pipeline
//   refill_pending_i     at least one refill outstanding
//   l0_flush_o           one-cycle invalidate pulse to all L0 caches
//   tag_req_*/tag_*_o    tag-SRAM write port request (clears a whole set)
module snitch_icache_flush_ctrl #(
  parameter int unsigned LINE_COUNT     = 128,
  parameter int unsigned WAY_COUNT      = 4,
  parameter int unsigned NR_FETCH_PORTS = 2,
  localparam int unsigned SET_ALIGN     = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_valid_i,
  output logic                      flush_ready_o,
  output logic                      busy_o,
  output logic                      lookup_stall_o,
  input  logic                      lookup_idle_i,
  input  logic                      refill_pending_i,
  output logic [NR_FETCH_PORTS-1:0] l0_flush_o,
  output logic                      tag_req_valid_o,
  input  logic                      tag_req_ready_i,
  output logic [SET_ALIGN-1:0]      tag_addr_o,
  output logic [WAY_COUNT-1:0]      tag_way_mask_o,
  output logic                      tag_write_o
);

  localparam logic [SET_ALIGN-1:0] LAST_SET = SET_ALIGN'(LINE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_INVAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SET_ALIGN-1:0] set_q, set_d;
  logic                 sw_q, sw_d;
  logic                 l0_q, l0_d;

  // State register; reset lands in DRAIN so the undefined tag SRAM is cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_DRAIN;
      set_q   <= '0;
      sw_q    <= 1'b0;
      l0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      sw_q    <= sw_d;
      l0_q    <= l0_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    sw_d    = sw_q;
    l0_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_valid_i) begin
          state_d = ST_DRAIN;
          sw_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Requests arriving while busy are left pending and served from IDLE.
        if (lookup_idle_i && !refill_pending_i) begin
          state_d = ST_INVAL;
          l0_d    = 1'b1;
        end
      end
      ST_INVAL: begin
        if (tag_req_ready_i) begin
          if (set_q == LAST_SET) begin
            state_d = ST_DONE;
            set_d   = '0;
          end else begin
            set_d = set_q + SET_ALIGN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sw_d    = 1'b0;
      end
      default: state_d = ST_DRAIN;
    endcase
  end

  // Outputs are pure decodes of registered state.
  assign busy_o          = (state_q != ST_IDLE);
  assign lookup_stall_o  = busy_o;
  assign flush_ready_o   = (state_q == ST_DONE) && sw_q;
  assign l0_flush_o      = {NR_FETCH_PORTS{l0_q}};
  assign tag_req_valid_o = (state_q == ST_INVAL);
  assign tag_write_o     = tag_req_valid_o;
  assign tag_addr_o      = set_q;
  assign tag_way_mask_o  = {WAY_COUNT{tag_req_valid_o}};

endmodule

// File: tb/tb_snitch_icache_flush_ctrl.sv
// Self-checking bench for snitch_icache_flush_ctrl: builds a per-cycle
// expected timeline from pre-generated input patterns and the flush rules.
module tb_snitch_icache_flush_ctrl;

  localparam int unsigned LINES = 8;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned PORTS = 2;
  localparam int unsigned SA    = 3;
  localparam int N = 64;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_valid_i;
  logic             flush_ready_o;
  logic             busy_o;
  logic             lookup_stall_o;
  logic             lookup_idle_i;
  logic             refill_pending_i;
  logic [PORTS-1:0] l0_flush_o;
  logic             tag_req_valid_o;
  logic             tag_req_ready_i;
  logic [SA-1:0]    tag_addr_o;
  logic [WAYS-1:0]  tag_way_mask_o;
  logic             tag_write_o;

  snitch_icache_flush_ctrl #(
    .LINE_COUNT(LINES), .WAY_COUNT(WAYS), .NR_FETCH_PORTS(PORTS)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .busy_o(busy_o), .lookup_stall_o(lookup_stall_o),
    .lookup_idle_i(lookup_idle_i), .refill_pending_i(refill_pending_i),
    .l0_flush_o(l0_flush_o),
    .tag_req_valid_o(tag_req_valid_o), .tag_req_ready_i(tag_req_ready_i),
    .tag_addr_o(tag_addr_o), .tag_way_mask_o(tag_way_mask_o),
    .tag_write_o(tag_write_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bit rdy[N], idl[N], pnd[N];
  bit e_busy[N], e_l0[N], e_val[N], e_rdy[N];
  int e_addr[N];
  int done_c;
  int acc[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " busy"},  32'(busy_o), 32'd1);
    check_eq({tag, " stall"}, 32'(lookup_stall_o), 32'd1);
    check_eq({tag, " ready"}, 32'(flush_ready_o), 32'd0);
    check_eq({tag, " l0"},    32'(l0_flush_o), 32'd0);
    check_eq({tag, " valid"}, 32'(tag_req_valid_o), 32'd0);
    check_eq({tag, " write"}, 32'(tag_write_o), 32'd0);
    check_eq({tag, " addr"},  32'(tag_addr_o), 32'd0);
    check_eq({tag, " mask"},  32'(tag_way_mask_o), 32'd0);
  endtask

  // Input patterns: 0 ideal, 1 refill pending for 5 cycles, 2 alternating ready, 3 random.
  task automatic gen(input int mode);
    for (int c = 0; c < N; c++) begin
      case (mode)
        0: begin idl[c] = 1; pnd[c] = 0; rdy[c] = 1; end
        1: begin idl[c] = 1; pnd[c] = (c >= 1 && c <= 5); rdy[c] = 1; end
        2: begin idl[c] = 1; pnd[c] = 0; rdy[c] = c[0]; end
        default: begin
          idl[c] = ($urandom_range(0, 2) != 0);
          pnd[c] = ($urandom_range(0, 2) == 0);
          rdy[c] = ($urandom_range(0, 1) != 0);
        end
      endcase
      if (c >= 30) begin idl[c] = 1; pnd[c] = 0; rdy[c] = 1; end
    end
  endtask

  // Timeline: cycle 0 is IDLE (software request), cycle 1 is the first DRAIN cycle.
  task automatic model(input bit sw);
    int d, k, c;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = 0; e_l0[i] = 0; e_val[i] = 0; e_rdy[i] = 0; e_addr[i] = 0;
    end
    d = 1;
    while (!(idl[d] && !pnd[d])) d++;
    for (int i = 1; i <= d; i++) e_busy[i] = 1;
    e_l0[d+1] = 1;
    k = 0;
    c = d + 1;
    while (k < int'(LINES)) begin
      e_busy[c] = 1; e_val[c] = 1; e_addr[c] = k;
      if (rdy[c]) k++;
      c++;
    end
    done_c = c;
    e_busy[c] = 1;
    e_rdy[c] = sw;
  endtask

  task automatic run_trial(input bit sw, input bit keep, input int abort_set, input string nm);
    int first;
    first = sw ? 0 : 1;
    acc.delete();
    for (int c = first; c <= done_c; c++) begin
      flush_valid_i    = sw || keep;
      lookup_idle_i    = idl[c];
      refill_pending_i = pnd[c];
      tag_req_ready_i  = rdy[c];
      @(negedge clk_i);
      check_eq($sformatf("%s c%0d busy", nm, c),  32'(busy_o), 32'(e_busy[c]));
      check_eq($sformatf("%s c%0d stall", nm, c), 32'(lookup_stall_o), 32'(e_busy[c]));
      check_eq($sformatf("%s c%0d l0", nm, c),    32'(l0_flush_o), e_l0[c] ? 32'((1 << PORTS) - 1) : 32'd0);
      check_eq($sformatf("%s c%0d valid", nm, c), 32'(tag_req_valid_o), 32'(e_val[c]));
      check_eq($sformatf("%s c%0d write", nm, c), 32'(tag_write_o), 32'(e_val[c]));
      check_eq($sformatf("%s c%0d mask", nm, c),  32'(tag_way_mask_o), e_val[c] ? 32'((1 << WAYS) - 1) : 32'd0);
      check_eq($sformatf("%s c%0d addr", nm, c),  32'(tag_addr_o), 32'(e_addr[c]));
      check_eq($sformatf("%s c%0d ready", nm, c), 32'(flush_ready_o), 32'(e_rdy[c]));
      if (tag_req_valid_o && tag_req_ready_i) acc.push_back(int'(tag_addr_o));
      if (abort_set >= 0 && e_val[c] && e_addr[c] == abort_set) begin
        rst_ni = 1'b0;
        #1;
        check_reset({nm, " async"});
        return;
      end
      @(posedge clk_i);
      #1;
    end
    check_eq({nm, " writes"}, 32'(acc.size()), 32'(LINES));
    foreach (acc[i]) check_eq($sformatf("%s write%0d", nm, i), 32'(acc[i]), 32'(i));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    flush_valid_i = 0; lookup_idle_i = 0; refill_pending_i = 0; tag_req_ready_i = 0;
    @(negedge clk_i);
    check_reset("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      flush_valid_i = 0;
      tag_req_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check_eq("gap busy", 32'(busy_o), 32'd0);
      check_eq("gap ready", 32'(flush_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    gen(0); model(0); run_trial(0, 0, -1, "init");
    gen(0); model(1); run_trial(1, 0, -1, "sw");
    gap(1);
    gen(1); model(1); run_trial(1, 0, -1, "drain");
    gen(2); model(1); run_trial(1, 0, -1, "bp");
    gen(0); model(1); run_trial(1, 0, 5, "abort");
    do_reset();
    gen(0); model(0); run_trial(0, 0, -1, "reinit");
    do_reset();
    gen(0); model(0); run_trial(0, 1, -1, "initreq");
    gen(0); model(1); run_trial(1, 0, -1, "req2");
    for (int t = 0; t < 20; t++) begin
      gap($urandom_range(0, 3));
      gen(3); model(1); run_trial(1, 0, -1, $sformatf("rnd%0d", t));
    end
    gap(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
